uart_dump_tx: RTL

UART transmitter serving as the outbound end of the FTDI serial link (`ftdi_tx`), complementing the existing 8N1 receiver that loads program ROM. It serializes single bytes from a valid/ready port. A built-in dump engine streams a synchronous memory, such as PRG-ROM, back to the host byte-by-byte, so a loaded image can be read back and verified.

---
 rtl/uart_dump_tx.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/uart_dump_tx.sv
// uart_dump_tx: 8N1 UART transmitter with a valid/ready byte port and a
// memory dump engine that streams DUMP_LEN bytes back to the host.
module uart_dump_tx #(
    parameter int DIV      = 104,
    parameter int DUMP_LEN = 16384,
    parameter int AW       = 14,
    parameter int MEM_LAT  = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    output logic          tx,
    input  logic [7:0]    tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    input  logic          dump_start,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_q,
    output logic          busy,
    output logic          dump_done
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} s_e;
    typedef enum logic [2:0] {D_IDLE, D_ADDR, D_WAIT, D_SEND, D_NEXT} d_e;

    localparam int          IW     = AW + 1;
    localparam logic [15:0] DIV_M1 = 16'(DIV - 1);
    localparam logic [2:0]  LAT_M1 = 3'(MEM_LAT - 1);
    localparam logic [AW:0] LAST   = IW'(DUMP_LEN - 1);

    s_e            s_q, s_d;
    d_e            d_q, d_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          tx_q, tx_d;
    logic [2:0]    lat_q, lat_d;
    logic [AW:0]   idx_q, idx_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          pend_q, pend_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          rdy_q, rdy_d;

    logic          load;
    logic [7:0]    ld_data;
    logic          ready_c;
    logic [AW:0]   idx_nxt;

    always_comb begin
        s_d     = s_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        lat_d   = lat_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        pend_d  = pend_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rdy_d   = 1'b1;
        load    = 1'b0;
        ld_data = tx_data;
        idx_nxt = idx_q + 1'b1;
        ready_c = rdy_q && (s_q == S_IDLE) && (d_q == D_IDLE) && !pend_q;

        if (dump_start && !busy_q) begin
            pend_d = 1'b1;
            busy_d = 1'b1;
        end
        if (tx_valid && ready_c) begin
            load = 1'b1;
        end

        unique case (d_q)
            D_IDLE: begin
                if (pend_q && (s_q == S_IDLE)) begin
                    d_d    = D_ADDR;
                    pend_d = 1'b0;
                    idx_d  = '0;
                    addr_d = '0;
                end
            end
            D_ADDR: begin
                lat_d = LAT_M1;
                d_d   = D_WAIT;
            end
            D_WAIT: begin
                if (lat_q == 3'd0) begin
                    load    = 1'b1;
                    ld_data = mem_q;
                    d_d     = D_SEND;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            D_SEND: begin
                if (s_q == S_IDLE) d_d = D_NEXT;
            end
            D_NEXT: begin
                if (idx_q == LAST) begin
                    done_d = 1'b1;
                    addr_d = '0;
                    busy_d = 1'b0;
                    d_d    = D_IDLE;
                end else begin
                    idx_d  = idx_nxt;
                    addr_d = idx_nxt[AW-1:0];
                    d_d    = D_ADDR;
                end
            end
            default: d_d = D_IDLE;
        endcase

        unique case (s_q)
            S_IDLE: begin
                if (load) begin
                    s_d   = S_START;
                    cnt_d = DIV_M1;
                    sh_d  = ld_data;
                end
            end
            S_START: begin
                if (cnt_q == 16'd0) begin
                    s_d   = S_DATA;
                    cnt_d = DIV_M1;
                    bit_d = 3'd0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == 16'd0) begin
                    cnt_d = DIV_M1;
                    sh_d  = {1'b0, sh_q[7:1]};
                    if (bit_q == 3'd7) s_d = S_STOP;
                    else bit_d = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                if (cnt_q == 16'd0) s_d = S_IDLE;
                else cnt_d = cnt_q - 16'd1;
            end
            default: s_d = S_IDLE;
        endcase

        // line level is registered from the state, one cycle behind it
        unique case (s_q)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = sh_q[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_q    <= S_IDLE;
            d_q    <= D_IDLE;
            cnt_q  <= '0;
            bit_q  <= '0;
            sh_q   <= '0;
            tx_q   <= 1'b1;
            lat_q  <= '0;
            idx_q  <= '0;
            addr_q <= '0;
            pend_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            rdy_q  <= 1'b0;
        end else begin
            s_q    <= s_d;
            d_q    <= d_d;
            cnt_q  <= cnt_d;
            bit_q  <= bit_d;
            sh_q   <= sh_d;
            tx_q   <= tx_d;
            lat_q  <= lat_d;
            idx_q  <= idx_d;
            addr_q <= addr_d;
            pend_q <= pend_d;
            busy_q <= busy_d;
            done_q <= done_d;
            rdy_q  <= rdy_d;
        end
    end

    assign tx        = tx_q;
    assign tx_ready  = ready_c;
    assign mem_addr  = addr_q;
    assign busy      = busy_q;
    assign dump_done = done_q;

endmodule
